// File: rtl/bus_arb.sv
// Two-master (instruction / data) to single system bus arbiter with round-robin
// tie-breaking, combinational pass-through while a master owns the bus, and a bus timeout.
module bus_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEN_WIDTH  = 4,
    parameter int TMO_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  nrst,
    // instruction master (read-only)
    input  logic [ADDR_WIDTH-1:0] i_IAddr,
    input  logic                  i_ICmd,
    output logic [DATA_WIDTH-1:0] o_IData,
    output logic                  o_IRdy,
    output logic                  o_IErr,
    // data master
    input  logic [ADDR_WIDTH-1:0] i_DAddr,
    input  logic                  i_DCmd,
    input  logic                  i_DRnW,
    input  logic [BEN_WIDTH-1:0]  i_DBen,
    input  logic [DATA_WIDTH-1:0] i_DData,
    output logic [DATA_WIDTH-1:0] o_DData,
    output logic                  o_DRdy,
    output logic                  o_DErr,
    // system bus
    output logic [ADDR_WIDTH-1:0] o_SAddr,
    output logic                  o_SCmd,
    output logic                  o_SRnW,
    output logic [BEN_WIDTH-1:0]  o_SBen,
    output logic [DATA_WIDTH-1:0] o_SData,
    input  logic [DATA_WIDTH-1:0] i_SData,
    input  logic                  i_SRdy,
    input  logic                  i_SErr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_t;

    typedef enum logic {
        MST_I = 1'b0,
        MST_D = 1'b1
    } mst_t;

    // A single-bit counter is enough when the timeout is disabled or one cycle long.
    localparam int               CNT_W    = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
    localparam bit               TMO_EN   = (TMO_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = TMO_EN ? CNT_W'(TMO_CYCLES - 1) : CNT_MAX;

    state_t           state_q, state_d;
    mst_t             lg_q, lg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             tmo_hit;
    logic             bus_err;
    logic             bus_rdy;
    logic             bus_done;
    logic [CNT_W-1:0] cnt_inc;

    // A genuine slave response in the timeout cycle beats the timeout; Err beats Rdy.
    assign tmo_hit  = TMO_EN && (cnt_q == CNT_LAST);
    assign bus_err  = i_SErr | (tmo_hit & ~i_SRdy);
    assign bus_rdy  = i_SRdy & ~i_SErr;
    assign bus_done = bus_err | bus_rdy;
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            lg_q    <= MST_I;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lg_q    <= lg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lg_d    = lg_q;
        cnt_d   = cnt_q;

        o_IData = '0;
        o_IRdy  = 1'b0;
        o_IErr  = 1'b0;
        o_DData = '0;
        o_DRdy  = 1'b0;
        o_DErr  = 1'b0;
        o_SAddr = '0;
        o_SCmd  = 1'b0;
        o_SRnW  = 1'b0;
        o_SBen  = '0;
        o_SData = '0;

        unique case (state_q)
            IDLE: begin
                // On a tie, the master that did not win last time is served.
                if (i_DCmd && (!i_ICmd || (lg_q == MST_I))) begin
                    state_d = OWN_D;
                    lg_d    = MST_D;
                    cnt_d   = '0;
                end else if (i_ICmd) begin
                    state_d = OWN_I;
                    lg_d    = MST_I;
                    cnt_d   = '0;
                end
            end

            OWN_I: begin
                o_SCmd  = 1'b1;
                o_SAddr = i_IAddr;
                o_SRnW  = 1'b1;
                o_SBen  = '1;
                o_SData = '0;
                o_IData = i_SData;
                o_IErr  = bus_err;
                o_IRdy  = bus_rdy;
                if (bus_done) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            OWN_D: begin
                o_SCmd  = 1'b1;
                o_SAddr = i_DAddr;
                o_SRnW  = i_DRnW;
                o_SBen  = i_DBen;
                o_SData = i_DData;
                o_DData = i_SData;
                o_DErr  = bus_err;
                o_DRdy  = bus_rdy;
                if (bus_done) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arb.sv
// Directed bench for bus_arb: expected master responses are queued when a request is
// issued and compared by a monitor whenever the arbiter returns Rdy or Err.
module tb_bus_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          nrst;
    logic [AW-1:0] i_IAddr;
    logic          i_ICmd;
    logic [DW-1:0] o_IData;
    logic          o_IRdy;
    logic          o_IErr;
    logic [AW-1:0] i_DAddr;
    logic          i_DCmd;
    logic          i_DRnW;
    logic [BW-1:0] i_DBen;
    logic [DW-1:0] i_DData;
    logic [DW-1:0] o_DData;
    logic          o_DRdy;
    logic          o_DErr;
    logic [AW-1:0] o_SAddr;
    logic          o_SCmd;
    logic          o_SRnW;
    logic [BW-1:0] o_SBen;
    logic [DW-1:0] o_SData;
    logic [DW-1:0] i_SData;
    logic          i_SRdy;
    logic          i_SErr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit            is_d;
        bit            err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    bus_arb #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .BEN_WIDTH (BW),
        .TMO_CYCLES(4)
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .i_IAddr(i_IAddr),
        .i_ICmd (i_ICmd),
        .o_IData(o_IData),
        .o_IRdy (o_IRdy),
        .o_IErr (o_IErr),
        .i_DAddr(i_DAddr),
        .i_DCmd (i_DCmd),
        .i_DRnW (i_DRnW),
        .i_DBen (i_DBen),
        .i_DData(i_DData),
        .o_DData(o_DData),
        .o_DRdy (o_DRdy),
        .o_DErr (o_DErr),
        .o_SAddr(o_SAddr),
        .o_SCmd (o_SCmd),
        .o_SRnW (o_SRnW),
        .o_SBen (o_SBen),
        .o_SData(o_SData),
        .i_SData(i_SData),
        .i_SRdy (i_SRdy),
        .i_SErr (i_SErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_slave();
        i_SRdy  = 1'b0;
        i_SErr  = 1'b0;
        i_SData = '0;
    endtask

    task automatic do_reset();
        nrst    = 1'b0;
        i_ICmd  = 1'b0;
        i_DCmd  = 1'b0;
        i_IAddr = '0;
        i_DAddr = '0;
        i_DRnW  = 1'b1;
        i_DBen  = '0;
        i_DData = '0;
        clear_slave();
        repeat (2) tick();
        nrst = 1'b1;
    endtask

    function automatic logic any_out();
        return (|{o_IData, o_IRdy, o_IErr, o_DData, o_DRdy, o_DErr,
                  o_SAddr, o_SCmd, o_SRnW, o_SBen, o_SData});
    endfunction

    task automatic expect_resp(input bit is_d, input bit err, input logic [DW-1:0] data);
        exp_t e;
        e.is_d = is_d;
        e.err  = err;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Response monitor: every Rdy/Err must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (o_IRdy || o_IErr || o_DRdy || o_DErr) begin
            check("resp_one_master", {63'b0, (o_IRdy | o_IErr) & (o_DRdy | o_DErr)}, 64'd0);
            if (sb_q.size() == 0) begin
                check("resp_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("resp_master", {63'b0, o_DRdy | o_DErr}, {63'b0, mon_e.is_d});
                check("resp_err", {63'b0, o_IErr | o_DErr}, {63'b0, mon_e.err});
                check("resp_rdy", {63'b0, o_IRdy | o_DRdy}, {63'b0, ~mon_e.err});
                check("resp_data", {32'b0, (mon_e.is_d ? o_DData : o_IData)}, {32'b0, mon_e.data});
                check("resp_other_data", {32'b0, (mon_e.is_d ? o_IData : o_DData)}, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        settle();
        check("rst_outputs_zero", {63'b0, any_out()}, 64'd0);

        // D read, slave answers two cycles after the first o_SCmd cycle
        i_DCmd  = 1'b1;
        i_DAddr = 32'h100;
        i_DRnW  = 1'b1;
        i_DBen  = 4'hF;
        i_DData = 32'h5555_5555;
        expect_resp(1'b1, 1'b0, 32'hDEAD_BEEF);
        settle();
        check("rd_idle_no_scmd", {63'b0, o_SCmd}, 64'd0);
        check("rd_idle_no_rdy", {63'b0, o_DRdy}, 64'd0);
        tick();
        check("rd_scmd", {63'b0, o_SCmd}, 64'd1);
        check("rd_saddr", {32'b0, o_SAddr}, 64'h100);
        check("rd_srnw", {63'b0, o_SRnW}, 64'd1);
        check("rd_sben", {60'b0, o_SBen}, 64'hF);
        tick();
        check("rd_wait_no_rdy", {63'b0, o_DRdy | o_DErr}, 64'd0);
        tick();
        i_SRdy  = 1'b1;
        i_SData = 32'hDEAD_BEEF;
        settle();
        check("rd_drdy", {63'b0, o_DRdy}, 64'd1);
        check("rd_ddata", {32'b0, o_DData}, 64'hDEAD_BEEF);
        check("rd_irdy_zero", {63'b0, o_IRdy}, 64'd0);
        tick();
        clear_slave();
        i_DCmd = 1'b0;
        settle();
        check("rd_back_idle", {63'b0, o_SCmd}, 64'd0);

        // Tie after reset: D first, I after a one-cycle gap, then D again
        do_reset();
        i_ICmd  = 1'b1;
        i_IAddr = 32'h200;
        i_DCmd  = 1'b1;
        i_DAddr = 32'h300;
        i_DRnW  = 1'b1;
        i_DBen  = 4'h3;
        i_DData = 32'hA5A5_A5A5;
        expect_resp(1'b1, 1'b0, 32'h1111_1111);
        tick();
        check("tie1_saddr_d", {32'b0, o_SAddr}, 64'h300);
        i_SRdy  = 1'b1;
        i_SData = 32'h1111_1111;
        settle();
        check("tie1_no_irdy", {63'b0, o_IRdy}, 64'd0);
        tick();
        clear_slave();
        i_DCmd = 1'b0;
        expect_resp(1'b0, 1'b0, 32'h2222_2222);
        settle();
        check("tie1_gap", {63'b0, o_SCmd}, 64'd0);
        tick();
        check("tie1_saddr_i", {32'b0, o_SAddr}, 64'h200);
        check("i_srnw", {63'b0, o_SRnW}, 64'd1);
        check("i_sben", {60'b0, o_SBen}, 64'hF);
        check("i_sdata_zero", {32'b0, o_SData}, 64'd0);
        i_SRdy  = 1'b1;
        i_SData = 32'h2222_2222;
        settle();
        check("i_idata", {32'b0, o_IData}, 64'h2222_2222);
        tick();
        clear_slave();
        i_DCmd = 1'b1;
        expect_resp(1'b1, 1'b0, 32'h3333_3333);
        tick();
        check("tie2_saddr_d", {32'b0, o_SAddr}, 64'h300);
        i_SRdy  = 1'b1;
        i_SData = 32'h3333_3333;
        tick();
        clear_slave();
        i_DCmd = 1'b0;
        expect_resp(1'b0, 1'b0, 32'h4444_4444);
        tick();
        check("tie2_saddr_i", {32'b0, o_SAddr}, 64'h200);
        i_SRdy  = 1'b1;
        i_SData = 32'h4444_4444;
        tick();
        clear_slave();
        i_ICmd = 1'b0;

        // Byte write with Err and Rdy together: Err wins
        i_DCmd  = 1'b1;
        i_DAddr = 32'h104;
        i_DRnW  = 1'b0;
        i_DBen  = 4'b0100;
        i_DData = 32'h00AB_0000;
        expect_resp(1'b1, 1'b1, 32'h0);
        tick();
        check("wr_srnw", {63'b0, o_SRnW}, 64'd0);
        check("wr_sben", {60'b0, o_SBen}, 64'h4);
        check("wr_sdata", {32'b0, o_SData}, 64'h00AB_0000);
        i_SErr = 1'b1;
        i_SRdy = 1'b1;
        settle();
        check("wr_derr", {63'b0, o_DErr}, 64'd1);
        check("wr_drdy_zero", {63'b0, o_DRdy}, 64'd0);
        tick();
        clear_slave();
        i_DCmd = 1'b0;
        settle();
        check("wr_back_idle", {63'b0, o_SCmd}, 64'd0);

        // Request dropped while idle has no effect
        i_ICmd = 1'b1;
        settle();
        i_ICmd = 1'b0;
        tick();
        check("drop_no_grant", {63'b0, o_SCmd}, 64'd0);

        // Timeout with a silent slave: Err in the 4th owned cycle
        i_ICmd  = 1'b1;
        i_IAddr = 32'h400;
        expect_resp(1'b0, 1'b1, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("tmo_no_err_early", {63'b0, o_IErr}, 64'd0);
        end
        tick();
        check("tmo_ierr", {63'b0, o_IErr}, 64'd1);
        check("tmo_scmd_held", {63'b0, o_SCmd}, 64'd1);
        tick();
        i_ICmd = 1'b0;
        check("tmo_scmd_off", {63'b0, o_SCmd}, 64'd0);

        // Response in the timeout cycle beats the timeout
        i_ICmd = 1'b1;
        expect_resp(1'b0, 1'b0, 32'hCAFE_F00D);
        repeat (4) tick();
        i_SRdy  = 1'b1;
        i_SData = 32'hCAFE_F00D;
        settle();
        check("tmo_col_irdy", {63'b0, o_IRdy}, 64'd1);
        check("tmo_col_ierr", {63'b0, o_IErr}, 64'd0);
        tick();
        clear_slave();
        i_ICmd = 1'b0;

        // Reset in the middle of a D transaction abandons it
        i_DCmd  = 1'b1;
        i_DAddr = 32'h500;
        i_DRnW  = 1'b1;
        i_DBen  = 4'hF;
        tick();
        check("mid_owned", {63'b0, o_SCmd}, 64'd1);
        nrst = 1'b0;
        tick();
        check("mid_rst_outputs_zero", {63'b0, any_out()}, 64'd0);
        nrst = 1'b1;
        expect_resp(1'b1, 1'b0, 32'h1234_5678);
        tick();
        check("post_rst_grant", {32'b0, o_SAddr}, 64'h500);
        i_SRdy  = 1'b1;
        i_SData = 32'h1234_5678;
        tick();
        clear_slave();
        i_DCmd = 1'b0;
        tick();

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
